mod_mul_seq: RTL and testbench

Sequential modular multiplier computing (iA * iB) mod iQ by MSB-first interleaved double-and-add. Each step reuses the modular-doubling datapath and adds a conditional modular add. It processes one multiplier bit per enabled cycle behind a valid/ready handshake on both sides. It is the parametrised, stateful successor to the combinational modular doubler and is the building block for modular exponentiation and NTT butterflies.

---
 rtl/mod_mul_seq_if.sv | 29 ++
 rtl/mod_mul_seq.sv | 116 +++++++++++
 tb/tb_mod_mul_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mod_mul_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mod_mul_seq_if
// Brief    : Operand/result handshake bundle for the sequential modular multiplier.
// Revision : 1.0
// ============================================================================
interface mod_mul_seq_if #(
  parameter int BITWIDTH = 8
);
  logic                iValid;
  logic                oReady;
  logic [BITWIDTH-1:0] iA;
  logic [BITWIDTH-1:0] iB;
  logic [BITWIDTH-1:0] iQ;
  logic                oValid;
  logic                iReady;
  logic [BITWIDTH-1:0] oData;

  modport master (
    output iValid, iA, iB, iQ, iReady,
    input  oReady, oValid, oData
  );

  modport slave (
    input  iValid, iA, iB, iQ, iReady,
    output oReady, oValid, oData
  );
endinterface
`default_nettype wire

// File: rtl/mod_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : mod_mul_seq
// Brief    : (iA * iB) mod iQ by MSB-first interleaved double-and-add, one bit/cycle.
// Revision : 1.0
// ============================================================================
module mod_mul_seq #(
  parameter int BITWIDTH = 8
) (
  input  logic          iClk,
  input  logic          iRstN,
  input  logic          iEn,
  input  logic          iClr,
  mod_mul_seq_if.slave  bus
);

  localparam int CNT_W = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

  localparam logic [1:0]       c_idle     = 2'd0;
  localparam logic [1:0]       c_run      = 2'd1;
  localparam logic [1:0]       c_done     = 2'd2;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(BITWIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [1:0]          state_q, state_d;
  logic [BITWIDTH-1:0] a_q, a_d;
  logic [BITWIDTH-1:0] b_q, b_d;
  logic [BITWIDTH-1:0] q_q, q_d;
  logic [BITWIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [BITWIDTH:0]   w_dbl;
  logic [BITWIDTH-1:0] w_dbl_red;
  logic [BITWIDTH:0]   w_sum;
  logic [BITWIDTH-1:0] w_acc_next;
  logic [BITWIDTH:0]   w_q_ext;

  // Both reductions subtract on the low BITWIDTH bits only: the true result is
  // below rQ, so the wrap-around of the narrow subtraction is exact.
  always_comb begin
    w_q_ext    = {1'b0, q_q};
    w_dbl      = {acc_q, 1'b0};
    w_dbl_red  = (w_dbl >= w_q_ext) ? (w_dbl[BITWIDTH-1:0] - q_q) : w_dbl[BITWIDTH-1:0];
    w_sum      = {1'b0, w_dbl_red} + {1'b0, (b_q[cnt_q] ? a_q : {BITWIDTH{1'b0}})};
    w_acc_next = (w_sum >= w_q_ext) ? (w_sum[BITWIDTH-1:0] - q_q) : w_sum[BITWIDTH-1:0];
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q <= c_idle;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (iClr) begin
      state_d = c_idle;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (iEn) begin
      case (state_q)
        c_idle: begin
          if (bus.iValid) begin
            a_d     = bus.iA;
            b_d     = bus.iB;
            q_d     = bus.iQ;
            acc_d   = '0;
            cnt_d   = c_cnt_last;
            state_d = c_run;
          end
        end
        c_run: begin
          acc_d = w_acc_next;
          if (cnt_q == '0) begin
            state_d = c_done;
          end else begin
            cnt_d = cnt_q - c_cnt_one;
          end
        end
        c_done: begin
          if (bus.iReady) begin
            state_d = c_idle;
          end
        end
        default: begin
          state_d = c_idle;
        end
      endcase
    end
  end

  always_comb begin
    bus.oReady = (state_q == c_idle) && iEn;
    bus.oValid = (state_q == c_done);
    bus.oData  = acc_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mod_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_mul_seq
// Brief    : Directed and random checks of mod_mul_seq at BITWIDTH=8.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mod_mul_seq;

  logic clk;
  logic rst_n;
  logic en;
  logic clr;
  int   total;
  int   bad;

  mod_mul_seq_if #(.BITWIDTH(8)) bus ();

  mod_mul_seq #(.BITWIDTH(8)) dut (
    .iClk  (clk),
    .iRstN (rst_n),
    .iEn   (en),
    .iClr  (clr),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q);
    int n;
    n = 0;
    while (!bus.oReady && n < 30) begin
      tick();
      n++;
    end
    bus.iA     = a;
    bus.iB     = b;
    bus.iQ     = q;
    bus.iValid = 1'b1;
    tick();
    bus.iValid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.oValid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic consume();
    bus.iReady = 1'b1;
    tick();
    bus.iReady = 1'b0;
  endtask

  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b,
                    input logic [7:0] q, input logic [7:0] exp);
    int lat;
    start(a, b, q);
    wait_valid(lat);
    check({tag, "_lat"}, lat, 8);
    check({tag, "_data"}, bus.oData, exp);
    consume();
    check({tag, "_vld_drop"}, bus.oValid, 0);
    check({tag, "_rdy_back"}, bus.oReady, 1);
  endtask

  initial begin
    int          lat;
    int          cnt;
    logic        seen;
    logic [7:0]  ra, rb, rq, rexp;

    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    en         = 1'b1;
    clr        = 1'b0;
    bus.iValid = 1'b0;
    bus.iReady = 1'b0;
    bus.iA     = '0;
    bus.iB     = '0;
    bus.iQ     = '0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_valid", bus.oValid, 0);
    check("rst_data", bus.oData, 0);
    check("rst_ready", bus.oReady, 1);
    en = 1'b0;
    #1;
    check("idle_ready_en0", bus.oReady, 0);
    en = 1'b1;
    #1;

    op("a10b2q23", 8'd10, 8'd2, 8'd23, 8'd20);
    op("a10b2q14", 8'd10, 8'd2, 8'd14, 8'd6);
    op("a10b2q20", 8'd10, 8'd2, 8'd20, 8'd0);
    op("a200b250", 8'd200, 8'd250, 8'd251, 8'd51);
    op("a254b254", 8'd254, 8'd254, 8'd255, 8'd1);
    op("a0b255", 8'd0, 8'd255, 8'd97, 8'd0);
    op("a96b0", 8'd96, 8'd0, 8'd97, 8'd0);

    // Stall: three frozen cycles after two RUN cycles.
    start(8'd10, 8'd2, 8'd23);
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", bus.oReady, 0);
      tick();
    end
    en = 1'b1;
    wait_valid(lat);
    check("stall_lat", lat + 5, 11);
    check("stall_data", bus.oData, 20);
    consume();

    // Abort on the 4th RUN cycle, with a competing iValid.
    start(8'd10, 8'd2, 8'd23);
    tick();
    tick();
    tick();
    clr        = 1'b1;
    bus.iValid = 1'b1;
    tick();
    clr        = 1'b0;
    bus.iValid = 1'b0;
    check("abort_valid", bus.oValid, 0);
    check("abort_ready", bus.oReady, 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.oValid) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);
    op("a7b9q11", 8'd7, 8'd9, 8'd11, 8'd8);

    // Backpressure, then an iReady pulse while disabled.
    start(8'd200, 8'd250, 8'd251);
    wait_valid(lat);
    check("bp_lat", lat, 8);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", bus.oValid, 1);
      check("bp_data", bus.oData, 51);
      check("bp_ready", bus.oReady, 0);
    end
    en         = 1'b0;
    bus.iReady = 1'b1;
    tick();
    check("en0_not_consumed", bus.oValid, 1);
    check("en0_data_hold", bus.oData, 51);
    en = 1'b1;
    tick();
    bus.iReady = 1'b0;
    check("bp_consumed", bus.oValid, 0);
    check("bp_ready_after", bus.oReady, 1);

    // Clear in DONE wins over a same-cycle iReady.
    start(8'd254, 8'd254, 8'd255);
    wait_valid(lat);
    check("clrdone_data", bus.oData, 1);
    clr        = 1'b1;
    bus.iReady = 1'b1;
    tick();
    clr        = 1'b0;
    bus.iReady = 1'b0;
    check("clrdone_valid", bus.oValid, 0);
    check("clrdone_data0", bus.oData, 0);

    // Reset mid-RUN.
    start(8'd200, 8'd250, 8'd251);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_valid", bus.oValid, 0);
    check("midrst_data", bus.oData, 0);
    check("midrst_ready", bus.oReady, 1);

    for (int i = 0; i < 1000; i++) begin
      rq   = 8'($urandom_range(255, 2));
      ra   = 8'($urandom_range(int'(rq) - 1, 0));
      rb   = 8'($urandom_range(255, 0));
      rexp = 8'((int'(ra) * int'(rb)) % int'(rq));
      start(ra, rb, rq);
      wait_valid(lat);
      check("rand_lat", lat, 8);
      check("rand_data", bus.oData, rexp);
      consume();
    end

    cnt = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
